fir_filter_axis_prog: RTL and testbench
=======================================

Name: fir_filter_axis_prog

Overview:
Parametrised successor to the team's fixed 8-tap AXI-Stream FIR. Direct-form FIR with runtime-writable signed coefficients, full AXI-Stream backpressure on both sides, round-and-shift output scaling, and tlast-triggered zero flush. Sits in the streaming DSP chain between sample sources and downstream AXI-Stream consumers.

Parameters:
DATA_W, 16, signed input/output sample width
COEF_W, 16, signed coefficient width
TAPS, 8, number of taps (>=1)
OUT_SHIFT, 0, arithmetic right shift applied to the accumulator before output (0..DATA_W+COEF_W-1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
s_axis_tdata  in  DATA_W  signed input sample
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  marks last sample of a frame
m_axis_tdata  out  DATA_W  signed filtered sample
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  marks last output of a frame (end of flush)
coef_wr_en  in  1  coefficient write strobe
coef_addr  in  max(1,$clog2(TAPS))  tap index; writes with index >= TAPS ignored
coef_wdata  in  COEF_W  signed coefficient value

Behaviour:
- Reset: all coefficients, shift register, flush counter cleared to 0; state RUN; m_axis_tdata=0, m_axis_tvalid=0, m_axis_tlast=0. s_axis_tready drops combinationally while rst is high.
- Output slot free: slot_free = !m_axis_tvalid || m_axis_tready.
- s_axis_tready = !rst && state==RUN && slot_free (combinational).
- States: RUN, FLUSH.
- RUN, accept (tvalid && tready): shift register moves up one tap, new sample enters tap 0. The output register loads y = sum over k of x[n-k]*c[k], where the sum includes the new sample. m_axis_tvalid=1 on the next cycle, so latency is 1 cycle. If tlast is set and TAPS>1: m_axis_tlast=0, flush_count=TAPS-1, go to FLUSH. If tlast is set and TAPS==1: m_axis_tlast=1 and stay in RUN.
- FLUSH: each cycle with slot_free, shift in 0, load the output, decrement flush_count. On the output with flush_count==1 before the decrement, set m_axis_tlast=1 and return to RUN. A frame of N samples therefore yields N+TAPS-1 outputs with exactly one tlast. No input is accepted during FLUSH.
- Output hold: while m_axis_tvalid && !m_axis_tready, tdata, tvalid and tlast are stable. On m_axis_tready with no new load, tvalid goes to 0.
- Arithmetic: products are full precision. Accumulator width is DATA_W+COEF_W+$clog2(TAPS), signed. If OUT_SHIFT>0, add 2^(OUT_SHIFT-1) (round half up), then arithmetic shift right by OUT_SHIFT, then reduce to DATA_W (see Optional Feature).
- Coefficient writes: accepted in any state, at any cycle. A write in cycle t affects outputs computed in cycle t+1 onward. A simultaneous write and accept uses the old coefficient.
- Reset mid-frame or mid-flush: aborts immediately. No tlast is emitted and all history is lost.

Optional Feature:
Macro FIR_FILTER_AXIS_PROG_SAT_EN.
- Defined: the scaled result saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Undefined: the scaled result wraps by truncating to the low DATA_W bits.

Test Plan:
- Impulse response: load coefficients 2,4,6,8,6,4,2,1 (TAPS=8, OUT_SHIFT=0); send a single sample 1 with tlast. Expect outputs 2,4,6,8,6,4,2,1, with m_axis_tlast only on the 8th and s_axis_tready low for 7 flush outputs.
- Backpressure: same coefficients, stream 1,1,1 and hold m_axis_tready=0 for 3 cycles after the first output. Expect m_axis_tdata held at 2, s_axis_tready=0, then outputs 2,6,12 in order with nothing lost.
- Rounding: OUT_SHIFT=2, c[0]=1, other coefficients 0. Input 6 gives 2; input -6 gives -1; input 5 gives 1.
- Saturation/wrap: all coefficients 32767; stream eight samples of 32767. With the macro defined, the 8th output is 32767. Without it, the 8th output is the low 16 bits of 8*32767^2, which is 0x0008.
- Coefficient update: write c[0]=3 in the same cycle a sample of value 1 is accepted (old c[0]=1). Expect output 1, then 3 for the next sample of value 1, all other coefficients being 0.
- Reset mid-flush: assert rst during the 3rd flush output. Expect m_axis_tvalid=0 and m_axis_tlast=0 the next cycle, s_axis_tready=1 after rst falls, and a new impulse of 1 producing 0 until coefficients are reloaded.

Source files
------------

// File: rtl/fir_filter_axis_prog.sv
// Direct-form AXI-Stream FIR with runtime-writable coefficients, round-and-shift scaling and tlast-triggered zero flush.
// Define FIR_FILTER_AXIS_PROG_SAT_EN to saturate the scaled output; otherwise it wraps to DATA_W bits.
module fir_filter_axis_prog #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 8,
  parameter int OUT_SHIFT = 0,
  localparam int ADDR_W   = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  input  logic              coef_wr_en,
  input  logic [ADDR_W-1:0] coef_addr,
  input  logic [COEF_W-1:0] coef_wdata
);

  localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
  localparam int HIST_N = (TAPS > 1) ? TAPS - 1 : 1;
  localparam logic signed [ACC_W:0] RND     = ((ACC_W+1)'(1) << OUT_SHIFT) >> 1;
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                   state;
  logic [ADDR_W-1:0]        flush_cnt;
  logic signed [COEF_W-1:0] coef    [TAPS];
  logic signed [DATA_W-1:0] hist_p0 [HIST_N];
  logic signed [DATA_W-1:0] data_p1;
  logic                     vld_p1;
  logic                     last_p1;

  logic                     slot_free;
  logic                     accept;
  logic                     flush_step;
  logic                     load;
  logic signed [DATA_W-1:0] x_new;
  logic signed [ACC_W-1:0]  acc;
  logic [ADDR_W:0]          addr_ext;

  function automatic logic signed [DATA_W-1:0] scale(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] r;
    r = ((ACC_W+1)'(a) + RND) >>> OUT_SHIFT;
`ifdef FIR_FILTER_AXIS_PROG_SAT_EN
    if (r > SAT_MAX)
      scale = SAT_MAX[DATA_W-1:0];
    else if (r < SAT_MIN)
      scale = SAT_MIN[DATA_W-1:0];
    else
      scale = r[DATA_W-1:0];
`else
    scale = r[DATA_W-1:0];
`endif
  endfunction

  assign slot_free     = !vld_p1 || m_axis_tready;
  assign s_axis_tready = !rst && (state == RUN) && slot_free;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign flush_step    = (state == FLUSH) && slot_free;
  assign load          = accept || flush_step;
  assign x_new         = (state == RUN) ? signed'(s_axis_tdata) : '0;
  assign addr_ext      = {1'b0, coef_addr};

  // Stage p0: window of the new sample plus history, multiply-accumulate against current coefficients
  always_comb begin
    acc = ACC_W'(x_new) * ACC_W'(coef[0]);
    for (int k = 1; k < TAPS; k++)
      acc = acc + ACC_W'(hist_p0[k-1]) * ACC_W'(coef[k]);
  end

  // Stage p1: registered output slot, history shift and frame/flush sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      flush_cnt <= '0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      data_p1   <= '0;
      for (int k = 0; k < TAPS; k++)   coef[k]    <= '0;
      for (int k = 0; k < HIST_N; k++) hist_p0[k] <= '0;
    end else begin
      if (coef_wr_en && (addr_ext < (ADDR_W+1)'(TAPS)))
        coef[coef_addr] <= signed'(coef_wdata);
      if (load) begin
        hist_p0[0] <= x_new;
        for (int k = 1; k < HIST_N; k++) hist_p0[k] <= hist_p0[k-1];
        data_p1 <= scale(acc);
        vld_p1  <= 1'b1;
        if (state == RUN) begin
          if (s_axis_tlast && (TAPS > 1)) begin
            last_p1   <= 1'b0;
            flush_cnt <= ADDR_W'(TAPS - 1);
            state     <= FLUSH;
          end else begin
            last_p1 <= s_axis_tlast;
          end
        end else begin
          flush_cnt <= flush_cnt - 1'b1;
          if (flush_cnt == ADDR_W'(1)) begin
            last_p1 <= 1'b1;
            state   <= RUN;
          end else begin
            last_p1 <= 1'b0;
          end
        end
      end else if (m_axis_tready) begin
        vld_p1  <= 1'b0;
        last_p1 <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = data_p1;
  assign m_axis_tvalid = vld_p1;
  assign m_axis_tlast  = last_p1;

endmodule

// File: tb/tb_fir_filter_axis_prog.sv
// Bench for fir_filter_axis_prog: directed cases plus a randomized stream scored against a convolution model.
module tb_fir_filter_axis_prog;

  localparam int T = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic signed [15:0] s_tdata;
  logic               s_tvalid, s_tready, s_tlast;
  logic signed [15:0] m_tdata;
  logic               m_tvalid, m_tready, m_tlast;
  logic               c_wr;
  logic [2:0]         c_addr;
  logic signed [15:0] c_wdata;

  logic signed [15:0] r_sd, r_md, r_wd;
  logic               r_sv, r_sr, r_sl, r_mv, r_mr, r_ml, r_wr;
  logic [1:0]         r_addr;

  fir_filter_axis_prog dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .coef_wr_en(c_wr), .coef_addr(c_addr), .coef_wdata(c_wdata)
  );

  fir_filter_axis_prog #(.TAPS(4), .OUT_SHIFT(2)) dut_r (
    .clk(clk), .rst(rst),
    .s_axis_tdata(r_sd), .s_axis_tvalid(r_sv), .s_axis_tready(r_sr), .s_axis_tlast(r_sl),
    .m_axis_tdata(r_md), .m_axis_tvalid(r_mv), .m_axis_tready(r_mr), .m_axis_tlast(r_ml),
    .coef_wr_en(r_wr), .coef_addr(r_addr), .coef_wdata(r_wd)
  );

  typedef struct { longint d; bit l; } exp_t;

  int     n_cmp, n_bad;
  longint mc [T];
  longint mw [T];
  exp_t   expq [$];

  logic               hs_in, hs_out, hold, in_l, pl;
  logic signed [15:0] in_d, pd;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint reduce(longint s, int sh);
    longint r;
    logic signed [15:0] t;
    r = s;
    if (sh > 0) r = (r + (longint'(1) <<< (sh - 1))) >>> sh;
`ifdef FIR_FILTER_AXIS_PROG_SAT_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`else
    t = r[15:0];
    r = t;
`endif
    return r;
  endfunction

  function automatic longint conv();
    longint s = 0;
    for (int k = 0; k < T; k++) s += mw[k] * mc[k];
    return s;
  endfunction

  // Convolution model: every accepted sample yields one output; tlast appends TAPS-1 zero-fed outputs
  task automatic model_push(input longint x, input bit last);
    for (int k = T - 1; k > 0; k--) mw[k] = mw[k-1];
    mw[0] = x;
    expq.push_back('{reduce(conv(), 0), 1'b0});
    if (last) begin
      for (int f = 1; f < T; f++) begin
        for (int k = T - 1; k > 0; k--) mw[k] = mw[k-1];
        mw[0] = 0;
        expq.push_back('{reduce(conv(), 0), (f == T - 1)});
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    hs_in  = s_tvalid && s_tready;
    in_d   = s_tdata;
    in_l   = s_tlast;
    hs_out = m_tvalid && m_tready;
    hold   = m_tvalid && !m_tready && !rst;
    pd     = m_tdata;
    pl     = m_tlast;
    @(posedge clk);
    #1;
    if (hold) begin
      check("hold_vld", m_tvalid, 1);
      check("hold_data", m_tdata, pd);
      check("hold_last", m_tlast, pl);
    end
  endtask

  task automatic tick_sb();
    exp_t e;
    tick();
    if (hs_out) begin
      check("sb_nonempty", expq.size() != 0, 1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        check("sb_data", pd, e.d);
        check("sb_last", pl, e.l);
      end
    end
    if (hs_in) model_push(in_d, in_l);
  endtask

  task automatic do_reset();
    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1; c_wr = 1'b0;
    r_sv = 1'b0; r_wr = 1'b0;
    tick();
    tick();
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tdata", m_tdata, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", s_tready, 1);
    for (int k = 0; k < T; k++) begin mc[k] = 0; mw[k] = 0; end
    expq.delete();
  endtask

  task automatic write_coef(input int a, input longint v);
    c_wr = 1'b1; c_addr = 3'(a); c_wdata = 16'(v);
    tick();
    c_wr = 1'b0;
    mc[a] = v;
  endtask

  task automatic r_send(input logic signed [15:0] x, input longint exp, input string tag);
    r_sd = x; r_sv = 1'b1;
    tick();
    r_sv = 1'b0;
    check({tag, "_vld"}, r_mv, 1);
    check(tag, r_md, exp);
  endtask

  longint imp [8];
  longint v;

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    c_wr = 1'b0; c_addr = '0; c_wdata = '0;
    r_sd = '0; r_sv = 1'b0; r_sl = 1'b0; r_mr = 1'b1; r_wr = 1'b0; r_addr = '0; r_wd = '0;
    imp = '{2, 4, 6, 8, 6, 4, 2, 1};

    // Impulse response with flush
    do_reset();
    for (int a = 0; a < T; a++) write_coef(a, imp[a]);
    s_tdata = 16'sd1; s_tvalid = 1'b1; s_tlast = 1'b1;
    #1;
    check("imp_ready_before", s_tready, 1);
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("imp_vld", m_tvalid, 1);
      check("imp_data", m_tdata, imp[i]);
      check("imp_last", m_tlast, (i == 7));
      check("imp_s_ready", s_tready, (i == 7));
      tick();
    end
    check("imp_idle_vld", m_tvalid, 0);

    // Backpressure: 1,1,1 with output stalled for 3 cycles
    s_tdata = 16'sd1; s_tvalid = 1'b1;
    tick();
    m_tready = 1'b0;
    #1;
    check("bp_first", m_tdata, 2);
    check("bp_ready_low", s_tready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_ready_stall", s_tready, 0);
    end
    m_tready = 1'b1;
    tick();
    check("bp_second", m_tdata, 6);
    tick();
    check("bp_third", m_tdata, 12);
    s_tvalid = 1'b0;
    tick();
    check("bp_drained", m_tvalid, 0);

    // Rounding on the OUT_SHIFT=2 instance
    do_reset();
    r_wr = 1'b1; r_addr = 2'd0; r_wd = 16'sd1;
    tick();
    r_wr = 1'b0;
    r_send(16'sd6, 2, "rnd_p6");
    r_send(-16'sd6, -1, "rnd_m6");
    r_send(16'sd5, 1, "rnd_p5");
    r_send(16'sd7, 2, "rnd_p7");
    r_send(-16'sd7, -2, "rnd_m7");
    for (int i = 0; i < 4; i++) begin
      v = longint'($urandom_range(0, 65535)) - 32768;
      r_send(16'(v), reduce(v, 2), "rnd_rand");
    end

    // Saturation / wrap with full-scale coefficients and samples
    do_reset();
    for (int a = 0; a < T; a++) write_coef(a, 32767);
    s_tdata = 16'sd32767; s_tvalid = 1'b1;
    for (int i = 0; i < 8; i++) tick_sb();
    s_tvalid = 1'b0;
`ifdef FIR_FILTER_AXIS_PROG_SAT_EN
    check("sat_8th", m_tdata, 32767);
`else
    check("wrap_8th", m_tdata, 8);
`endif
    tick_sb();
    check("sat_sb_empty", expq.size(), 0);

    // Coefficient write coinciding with an accept uses the old value
    do_reset();
    write_coef(0, 1);
    s_tdata = 16'sd1; s_tvalid = 1'b1;
    c_wr = 1'b1; c_addr = 3'd0; c_wdata = 16'sd3;
    tick();
    c_wr = 1'b0;
    check("cupd_old", m_tdata, 1);
    tick();
    s_tvalid = 1'b0;
    check("cupd_new", m_tdata, 3);
    tick();

    // Reset during the 3rd flush output
    do_reset();
    for (int a = 0; a < T; a++) write_coef(a, imp[a]);
    s_tdata = 16'sd1; s_tvalid = 1'b1; s_tlast = 1'b1;
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    tick();
    tick();
    tick();
    check("rmf_flush3", m_tdata, 8);
    rst = 1'b1;
    #1;
    check("rmf_ready_in_rst", s_tready, 0);
    tick();
    check("rmf_vld", m_tvalid, 0);
    check("rmf_last", m_tlast, 0);
    rst = 1'b0;
    #1;
    check("rmf_ready_after", s_tready, 1);
    s_tdata = 16'sd1; s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0;
    check("rmf_new_vld", m_tvalid, 1);
    check("rmf_new_zero", m_tdata, 0);
    check("rmf_new_last", m_tlast, 0);
    tick();

    // Randomized stream with random backpressure and frames
    do_reset();
    for (int a = 0; a < T; a++) begin
      case ($urandom_range(0, 3))
        0: v = 32767;
        1: v = -32768;
        default: v = longint'($urandom_range(0, 65535)) - 32768;
      endcase
      write_coef(a, v);
    end
    for (int i = 0; i < 600; i++) begin
      s_tvalid = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 5))
        0: s_tdata = 16'sd32767;
        1: s_tdata = -16'sd32768;
        default: s_tdata = 16'($urandom_range(0, 65535));
      endcase
      s_tlast  = ($urandom_range(0, 9) == 0);
      m_tready = ($urandom_range(0, 9) < 7);
      tick_sb();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (expq.size() == 0 && !m_tvalid) break;
      tick_sb();
    end
    check("rand_drain_empty", expq.size(), 0);
    check("rand_drain_vld", m_tvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
